// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the parametrised packet FIFO.
package sync_fifo_pkg;
  localparam int DEF_SRC_W  = 8;
  localparam int DEF_DST_W  = 8;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 3;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;
  localparam int CNT_W      = DEF_ADDR_W + 1;

  // Width of one packed {src, dst, data} word
  function automatic int word_w(input int src_w, input int dst_w, input int data_w);
    return src_w + dst_w + data_w;
  endfunction
endpackage

// File: rtl/fifo_regmem.sv
// One-write / one-read register array backing the packet FIFO.
// Read is combinational; the owner registers the output.
module fifo_regmem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH  = word_w(DEF_SRC_W, DEF_DST_W, DEF_DATA_W),
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem_q [2**ADDR_W];

  // Storage write; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_fifo_pkt.sv
// Synchronous packet FIFO carrying {src, dst, data} words with occupancy,
// programmable almost-full/almost-empty flags, sticky overflow/underflow
// errors and a registered read port with a valid strobe.
module sync_fifo_pkt
  import sync_fifo_pkg::*;
#(
  parameter int SRC_W  = DEF_SRC_W,
  parameter int DST_W  = DEF_DST_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int AF_LVL = (2 ** ADDR_W) - 2,
  parameter int AE_LVL = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              writep,
  input  logic [SRC_W-1:0]  src_in,
  input  logic [DST_W-1:0]  dst_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              readp,
  output logic [SRC_W-1:0]  src_out,
  output logic [DST_W-1:0]  dst_out,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              emptyp,
  output logic              fullp,
  output logic              afullp,
  output logic              aemptyp,
  output logic [ADDR_W:0]   count,
  input  logic              err_clr,
  output logic              ovf_err,
  output logic              udf_err
);
  localparam int FIFO_DEPTH = 2 ** ADDR_W;
  localparam int WORD_W     = word_w(SRC_W, DST_W, DATA_W);

  if (AF_LVL < 0 || AF_LVL > FIFO_DEPTH) begin : g_bad_af
    $error("sync_fifo_pkt: AF_LVL %0d outside 0..%0d", AF_LVL, FIFO_DEPTH);
  end
  if (AE_LVL < 0 || AE_LVL > FIFO_DEPTH) begin : g_bad_ae
    $error("sync_fifo_pkt: AE_LVL %0d outside 0..%0d", AE_LVL, FIFO_DEPTH);
  end

  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [WORD_W-1:0] out_q, out_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [WORD_W-1:0] mem_rdata;
  logic              wr_ok, rd_ok;

  // Flags decode the registered count so accept decisions see start-of-cycle state
  assign emptyp  = (count_q == '0);
  assign fullp   = (count_q == (ADDR_W + 1)'(FIFO_DEPTH));
  assign afullp  = (int'(count_q) >= AF_LVL);
  assign aemptyp = (int'(count_q) <= AE_LVL);

  assign wr_ok = writep & ~fullp;
  assign rd_ok = readp & ~emptyp;

  fifo_regmem #(
    .WIDTH  (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (head_q),
    .wdata ({src_in, dst_in, data_in}),
    .raddr (tail_q),
    .rdata (mem_rdata)
  );

  // Next-state: pointers wrap naturally, count tracks accepted traffic only
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    out_d      = out_q;
    rd_valid_d = rd_ok;
    ovf_d      = ovf_q;
    udf_d      = udf_q;

    if (wr_ok) head_d = head_q + ADDR_W'(1);
    if (rd_ok) begin
      tail_d = tail_q + ADDR_W'(1);
      out_d  = mem_rdata;
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    // A new error event outranks a coincident clear
    if (err_clr)          ovf_d = 1'b0;
    if (writep && fullp)  ovf_d = 1'b1;
    if (err_clr)          udf_d = 1'b0;
    if (readp && emptyp)  udf_d = 1'b1;
  end

  // State registers; reset discards all contents and clears the output port
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      out_q      <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      out_q      <= out_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign {src_out, dst_out, data_out} = out_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign ovf_err  = ovf_q;
  assign udf_err  = udf_q;
endmodule

// File: tb/tb_sync_fifo_pkt.sv
// Directed bench for sync_fifo_pkt at default parameters (DEPTH 8, AF 6, AE 2).
module tb_sync_fifo_pkt;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        writep = 1'b0, readp = 1'b0, err_clr = 1'b0;
  logic [7:0]  src_in = '0, dst_in = '0;
  logic [31:0] data_in = '0;
  logic [7:0]  src_out, dst_out;
  logic [31:0] data_out;
  logic        rd_valid, emptyp, fullp, afullp, aemptyp, ovf_err, udf_err;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sync_fifo_pkt dut (
    .clk(clk), .rstn(rstn), .writep(writep), .src_in(src_in), .dst_in(dst_in),
    .data_in(data_in), .readp(readp), .src_out(src_out), .dst_out(dst_out),
    .data_out(data_out), .rd_valid(rd_valid), .emptyp(emptyp), .fullp(fullp),
    .afullp(afullp), .aemptyp(aemptyp), .count(count), .err_clr(err_clr),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  typedef struct {
    logic        wr, rd, clr;
    logic [7:0]  s, d;
    logic [31:0] dat;
    int          cnt;
    logic        vld;
    logic [7:0]  es, ed;
    logic [31:0] edat;
    logic        ovf, udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wr, input logic rd, input logic clr,
                              input logic [7:0] s, input logic [7:0] d, input logic [31:0] dat,
                              input int cnt, input logic vld,
                              input logic [7:0] es, input logic [7:0] ed, input logic [31:0] edat,
                              input logic ovf, input logic udf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.s = s; v.d = d; v.dat = dat;
    v.cnt = cnt; v.vld = vld; v.es = es; v.ed = ed; v.edat = edat;
    v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic vld,
                           input logic ovf, input logic udf);
    chk({tag, ".count"},    64'(count),    64'(cnt));
    chk({tag, ".emptyp"},   64'(emptyp),   64'(cnt == 0));
    chk({tag, ".fullp"},    64'(fullp),    64'(cnt == DEPTH));
    chk({tag, ".afullp"},   64'(afullp),   64'(cnt >= AF));
    chk({tag, ".aemptyp"},  64'(aemptyp),  64'(cnt <= AE));
    chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(vld));
    chk({tag, ".ovf_err"},  64'(ovf_err),  64'(ovf));
    chk({tag, ".udf_err"},  64'(udf_err),  64'(udf));
  endtask

  task automatic chk_out(input string tag, input logic [7:0] s, input logic [7:0] d,
                         input logic [31:0] dat);
    chk({tag, ".src_out"},  64'(src_out),  64'(s));
    chk({tag, ".dst_out"},  64'(dst_out),  64'(d));
    chk({tag, ".data_out"}, 64'(data_out), 64'(dat));
  endtask

  task automatic drive(input logic wr, input logic rd, input logic clr,
                       input logic [7:0] s, input logic [7:0] d, input logic [31:0] dat);
    writep = wr; readp = rd; err_clr = clr;
    src_in = s; dst_in = d; data_in = dat;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Word k of the hand sequences
  function automatic logic [7:0]  ws(input int k); return 8'(k); endfunction
  function automatic logic [7:0]  wd(input int k); return 8'(k) ^ 8'hF0; endfunction
  function automatic logic [31:0] wv(input int k); return 32'hC0DE_0000 + 32'(k); endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Table: single word round trip, fill to full, overflow, drain, clear
    vecs.push_back(mk(1, 0, 0, 8'h11, 8'h22, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 8'h11, 8'h22, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(1, 0, 0, 8'h10 + 8'(k), 8'h20 + 8'(k), 32'hA000_0000 + 32'(k),
                        k, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'hFF, 8'hFF, 32'hFFFF_FFFF, 8, 0, 0, 0, 0, 1, 0));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8 - k, 1,
                        8'h10 + 8'(k), 8'h20 + 8'(k), 32'hA000_0000 + 32'(k), 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset state
    rstn = 1'b0;
    tick();
    tick();
    chk_state("reset", 0, 0, 0, 0);
    chk_out("reset", 8'h00, 8'h00, 32'h0);
    rstn = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].s, vecs[i].d, vecs[i].dat);
      tick();
      chk_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].vld, vecs[i].ovf, vecs[i].udf);
      if (vecs[i].vld)
        chk_out($sformatf("vec%0d", i), vecs[i].es, vecs[i].ed, vecs[i].edat);
    end

    // Streaming: fill to 4, then 20 cycles of simultaneous read/write
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, ws(k), wd(k), wv(k));
      tick();
      chk_state($sformatf("sfill%0d", k), k + 1, 0, 0, 0);
    end
    for (int c = 0; c < 20; c++) begin
      drive(1, 1, 0, ws(c + 4), wd(c + 4), wv(c + 4));
      tick();
      chk_state($sformatf("stream%0d", c), 4, 1, 0, 0);
      chk_out($sformatf("stream%0d", c), ws(c), wd(c), wv(c));
    end
    for (int c = 20; c < 24; c++) begin
      drive(0, 1, 0, 0, 0, 0);
      tick();
      chk_state($sformatf("sdrain%0d", c), 23 - c, 1, 0, 0);
      chk_out($sformatf("sdrain%0d", c), ws(c), wd(c), wv(c));
    end

    // Empty with both requested: write only, underflow flagged
    drive(1, 1, 0, ws(170), wd(170), wv(170));
    tick();
    chk_state("empty_rw", 1, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 0);
    tick();
    chk_state("udf_clr", 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    tick();
    chk_state("empty_rw_pop", 0, 1, 0, 0);
    chk_out("empty_rw_pop", ws(170), wd(170), wv(170));
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk_state("hold", 0, 0, 0, 0);
    chk_out("hold", ws(170), wd(170), wv(170));

    // Full with both requested: read only, incoming word dropped
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 0, ws(100 + k), wd(100 + k), wv(100 + k));
      tick();
      chk_state($sformatf("ffill%0d", k), k + 1, 0, 0, 0);
    end
    drive(1, 1, 0, ws(200), wd(200), wv(200));
    tick();
    chk_state("full_rw", 7, 1, 1, 0);
    chk_out("full_rw", ws(100), wd(100), wv(100));
    for (int k = 1; k < 8; k++) begin
      drive(0, 1, 0, 0, 0, 0);
      tick();
      chk_state($sformatf("fdrain%0d", k), 7 - k, 1, 1, 0);
      chk_out($sformatf("fdrain%0d", k), ws(100 + k), wd(100 + k), wv(100 + k));
    end

    // Asynchronous reset in the middle of a cycle with 5 words stored
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, ws(50 + k), wd(50 + k), wv(50 + k));
      tick();
      chk_state($sformatf("rfill%0d", k), k + 1, 0, 1, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rstn = 1'b0;
    #1;
    chk_state("async_rst", 0, 0, 0, 0);
    chk_out("async_rst", 8'h00, 8'h00, 32'h0);
    tick();
    rstn = 1'b1;
    drive(0, 1, 0, 0, 0, 0);
    tick();
    chk_state("post_rst_rd", 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
